key_entry_unit: RTL and testbench
=================================

KEY_ENTRY_UNIT -- requirements
Module: key_entry_unit

Interface
REQ-001 SHALL have: IN_clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: IN_reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: IN_key_pressed  input  1  level, high while any keypad key is held; already debounced.
REQ-004 SHALL have: IN_key_code  input  4  held key. 0-9 digit, A add, B sub, C and, D or, E cmp, F equals.
REQ-005 SHALL have: OUT_SRCH, OUT_SRCL  output  8 each  first operand, high and low byte.
REQ-006 SHALL have: OUT_DSTH, OUT_DSTL  output  8 each  second operand, high and low byte.
REQ-007 SHALL have: OUT_ALU_OP  output  4  latched operator code, A-E.
REQ-008 SHALL have: OUT_finish  output  1  one-cycle pulse requesting calculation.
REQ-009 SHALL have: OUT_state  output  2  entry state, S0=0, S1=1, S2=2, S3=3.
REQ-010 SHALL have: OUT_flag  output  2  digits entered in the current operand, 0-3.
REQ-011 SHALL have: OUT_calculating  output  4  value 1 while a result is held for display, else 0.

Function
REQ-012 SHALL register IN_key_pressed and create one key event on each 0->1 transition; IN_key_code is sampled in that same cycle.
REQ-013 SHALL produce no further event while the key stays held.
REQ-014 SHALL apply each key event one cycle after the press is detected (2-cycle latency from the IN_key_pressed rise).
REQ-015 States: S0 idle or result held; S1 entering first operand; S2 operator entered; S3 entering second operand.
REQ-016 Digit in S0: go to S1; SRC=digit; DST=0; OUT_flag=1; OUT_ALU_OP=0; OUT_calculating=0.
REQ-017 Digit in S1 or S3 with OUT_flag<3: operand=operand*10+digit, computed as (v<<3)+(v<<1)+d, 16-bit; OUT_flag increments.
REQ-018 Digit in S1 or S3 with OUT_flag==3: ignored; operand and flag unchanged.
REQ-019 Digit in S2: go to S3; DST=digit; OUT_flag=1.
REQ-020 Operator (A-E) in S1: latch OUT_ALU_OP; go to S2; OUT_flag unchanged.
REQ-021 Operator in S2: replaces OUT_ALU_OP; stay in S2.
REQ-022 Operator in S0 or S3: ignored.
REQ-023 Equals (F) in S3: OUT_finish=1 for exactly one cycle, with operands and OUT_ALU_OP stable in that cycle and held afterwards; go to S0; OUT_flag=0; OUT_calculating=1.
REQ-024 Equals in S0, S1 or S2: ignored; OUT_finish stays 0.
REQ-025 OUT_calculating SHALL stay 1 until the next accepted digit, then clear.
REQ-026 Operands and OUT_ALU_OP SHALL hold their values in S0 until a digit starts a new entry.
REQ-027 Because at most 3 digits are accepted, operands never exceed 999; no overflow handling is needed.
REQ-028 OUT_finish SHALL never be asserted for two consecutive cycles.
REQ-029 A new key event in the cycle after OUT_finish SHALL be processed normally from S0.

Reset
REQ-030 IN_reset high at a clock edge SHALL force S0 and set all outputs to 0, including operands, OUT_ALU_OP, OUT_finish, OUT_flag and OUT_calculating; the edge register is cleared.
REQ-031 Reset SHALL take priority over a simultaneous key event; that event is discarded.
REQ-032 A key still held when reset deasserts SHALL NOT produce an event until it is released and pressed again.
REQ-033 Reset during entry or in the OUT_finish cycle SHALL abort with no further OUT_finish.

Verification
REQ-034 Keys 1,2,A,3,4,F -> one OUT_finish pulse with SRC=0x000C, DST=0x0022, OUT_ALU_OP=A; then OUT_state=0, OUT_flag=0, OUT_calculating=1.
REQ-035 Keys 1,2,3,4 -> SRC=0x007B, OUT_flag=3, OUT_state=1; the fourth digit has no effect.
REQ-036 Keys 5,A,B,3,F -> OUT_ALU_OP=B, SRC=0x0005, DST=0x0003, one OUT_finish.
REQ-037 Keys 9,9,9,E,9,9,9,F -> SRC=DST=0x03E7, OUT_ALU_OP=E; then digit 7 -> OUT_state=1, SRC=0x0007, DST=0, OUT_calculating=0.
REQ-038 Key 8 held 50 cycles, then F in S1 -> exactly one digit event, SRC=0x0008, OUT_finish stays 0.
REQ-039 IN_reset asserted after 4,A,6 -> next cycle all outputs 0, OUT_state=0; a subsequent F gives no OUT_finish.

Source files
------------

// File: rtl/key_entry_unit.sv
// Keypad entry unit: turns debounced key presses into two decimal operands of up to
// three digits, an operator code and a one-cycle calculate request.
module key_entry_unit (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic       IN_key_pressed,
    input  logic [3:0] IN_key_code,
    output logic [7:0] OUT_SRCH,
    output logic [7:0] OUT_SRCL,
    output logic [7:0] OUT_DSTH,
    output logic [7:0] OUT_DSTL,
    output logic [3:0] OUT_ALU_OP,
    output logic       OUT_finish,
    output logic [1:0] OUT_state,
    output logic [1:0] OUT_flag,
    output logic [3:0] OUT_calculating
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSrc   = 2'd1,
        StOp    = 2'd2,
        StDst   = 2'd3
    } state_e;

    localparam logic [3:0] KeyEquals = 4'hF;

    logic       key_prev_q;
    logic       key_evt_q;
    logic [3:0] key_code_q;

    state_e     state_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [3:0] alu_op_q;
    logic       finish_q;
    logic [1:0] flag_q;
    logic       calc_q;

    logic        is_digit;
    logic        is_op;
    logic        is_equals;
    logic [15:0] digit_ext;
    logic [15:0] src_acc;
    logic [15:0] dst_acc;

    // Edge detector: one event per press, code captured on the rising edge. Loading the
    // current level during reset keeps a key held across reset from firing afterwards.
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            key_prev_q <= IN_key_pressed;
            key_evt_q  <= 1'b0;
            key_code_q <= 4'h0;
        end else begin
            key_prev_q <= IN_key_pressed;
            key_evt_q  <= IN_key_pressed & ~key_prev_q;
            if (IN_key_pressed && !key_prev_q) begin
                key_code_q <= IN_key_code;
            end
        end
    end

    // Key decode and decimal shift-in (v*10 + d as two shifts and adds).
    always_comb begin
        is_digit  = (key_code_q <= 4'd9);
        is_op     = (key_code_q >= 4'hA) && (key_code_q <= 4'hE);
        is_equals = (key_code_q == KeyEquals);
        digit_ext = {12'h000, key_code_q};
        src_acc   = (src_q << 3) + (src_q << 1) + digit_ext;
        dst_acc   = (dst_q << 3) + (dst_q << 1) + digit_ext;
    end

    // Entry FSM with registered outputs; finish is a single-cycle pulse.
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            state_q  <= StIdle;
            src_q    <= 16'h0000;
            dst_q    <= 16'h0000;
            alu_op_q <= 4'h0;
            finish_q <= 1'b0;
            flag_q   <= 2'd0;
            calc_q   <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (key_evt_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (is_digit) begin
                            state_q  <= StSrc;
                            src_q    <= digit_ext;
                            dst_q    <= 16'h0000;
                            flag_q   <= 2'd1;
                            alu_op_q <= 4'h0;
                            calc_q   <= 1'b0;
                        end
                    end
                    StSrc: begin
                        if (is_digit) begin
                            if (flag_q != 2'd3) begin
                                src_q  <= src_acc;
                                flag_q <= flag_q + 2'd1;
                            end
                        end else if (is_op) begin
                            alu_op_q <= key_code_q;
                            state_q  <= StOp;
                        end
                    end
                    StOp: begin
                        if (is_digit) begin
                            state_q <= StDst;
                            dst_q   <= digit_ext;
                            flag_q  <= 2'd1;
                        end else if (is_op) begin
                            alu_op_q <= key_code_q;
                        end
                    end
                    StDst: begin
                        if (is_digit) begin
                            if (flag_q != 2'd3) begin
                                dst_q  <= dst_acc;
                                flag_q <= flag_q + 2'd1;
                            end
                        end else if (is_equals) begin
                            finish_q <= 1'b1;
                            state_q  <= StIdle;
                            flag_q   <= 2'd0;
                            calc_q   <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Output mapping straight from state registers.
    always_comb begin
        OUT_SRCH        = src_q[15:8];
        OUT_SRCL        = src_q[7:0];
        OUT_DSTH        = dst_q[15:8];
        OUT_DSTL        = dst_q[7:0];
        OUT_ALU_OP      = alu_op_q;
        OUT_finish      = finish_q;
        OUT_state       = state_q;
        OUT_flag        = flag_q;
        OUT_calculating = {3'b000, calc_q};
    end

endmodule

// File: tb/tb_key_entry_unit.sv
// Bench for key_entry_unit: key-level reference model compared every cycle, plus
// literal expectations for the directed sequences.
module tb_key_entry_unit;

    logic       clk;
    logic       rst;
    logic       kp;
    logic [3:0] kc;
    logic [7:0] srch, srcl, dsth, dstl;
    logic [3:0] alu_op;
    logic       finish;
    logic [1:0] state;
    logic [1:0] flag;
    logic [3:0] calc;

    key_entry_unit dut (
        .IN_clk          (clk),
        .IN_reset        (rst),
        .IN_key_pressed  (kp),
        .IN_key_code     (kc),
        .OUT_SRCH        (srch),
        .OUT_SRCL        (srcl),
        .OUT_DSTH        (dsth),
        .OUT_DSTL        (dstl),
        .OUT_ALU_OP      (alu_op),
        .OUT_finish      (finish),
        .OUT_state       (state),
        .OUT_flag        (flag),
        .OUT_calculating (calc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit prev;
        bit pend;
        int pcode;
        int st;
        int src;
        int dst;
        int op;
        int fin;
        int flag;
        int calc;
    } mdl_t;

    mdl_t m;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   en_chk = 0;
    int   fin_cnt = 0;
    int   fin_src = 0;
    int   fin_dst = 0;
    int   fin_op  = 0;
    bit   prev_fin = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Key-level behaviour: each press becomes one key, applied two cycles after the rise.
    function automatic mdl_t step(mdl_t c, logic r, logic p, logic [3:0] code);
        mdl_t n;
        int   d;
        n = c;
        n.fin = 0;
        if (r) begin
            n = '{default: 0};
            n.prev = p;
            return n;
        end
        if (c.pend) begin
            d = c.pcode;
            if (d <= 9) begin
                if (c.st == 0) begin
                    n.st = 1; n.src = d; n.dst = 0; n.flag = 1; n.op = 0; n.calc = 0;
                end else if (c.st == 2) begin
                    n.st = 3; n.dst = d; n.flag = 1;
                end else if (c.flag < 3) begin
                    if (c.st == 1) n.src = c.src * 10 + d;
                    else           n.dst = c.dst * 10 + d;
                    n.flag = c.flag + 1;
                end
            end else if (d <= 14) begin
                if (c.st == 1 || c.st == 2) begin
                    n.op = d; n.st = 2;
                end
            end else if (c.st == 3) begin
                n.fin = 1; n.st = 0; n.flag = 0; n.calc = 1;
            end
        end
        n.pend = p && !c.prev;
        if (n.pend) n.pcode = int'(code);
        n.prev = p;
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst, kp, kc);

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (en_chk) begin
            chk("src",    int'({srch, srcl}), m.src);
            chk("dst",    int'({dsth, dstl}), m.dst);
            chk("alu_op", int'(alu_op), m.op);
            chk("finish", int'(finish), m.fin);
            chk("state",  int'(state), m.st);
            chk("flag",   int'(flag), m.flag);
            chk("calc",   int'(calc), m.calc);
            chk("finish_twice", int'(prev_fin & finish), 0);
            if (finish) begin
                fin_cnt++;
                fin_src = int'({srch, srcl});
                fin_dst = int'({dsth, dstl});
                fin_op  = int'(alu_op);
            end
            prev_fin = finish;
        end
    end

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        kp = 1'b1;
        kc = code;
        repeat (hold) @(negedge clk);
        kp = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) press(seq[i], 2, 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int f0;

    initial begin
        rst = 1'b1;
        kp  = 1'b0;
        kc  = 4'h0;
        @(negedge clk);
        @(negedge clk);
        en_chk = 1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_src", int'({srch, srcl}), 0);
        chk("reset_calc", int'(calc), 0);

        // 12 A 34 =
        f0 = fin_cnt;
        keys('{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'hF});
        chk("v1_fin_cnt", fin_cnt - f0, 1);
        chk("v1_fin_src", fin_src, 16'h000C);
        chk("v1_fin_dst", fin_dst, 16'h0022);
        chk("v1_fin_op", fin_op, 4'hA);
        chk("v1_state", int'(state), 0);
        chk("v1_flag", int'(flag), 0);
        chk("v1_calc", int'(calc), 1);

        // Fourth digit is dropped.
        keys('{4'h1, 4'h2, 4'h3, 4'h4});
        chk("v2_src", int'({srch, srcl}), 16'h007B);
        chk("v2_flag", int'(flag), 3);
        chk("v2_state", int'(state), 1);
        chk("v2_calc", int'(calc), 0);
        do_reset();

        // Operator replaced in S2.
        f0 = fin_cnt;
        keys('{4'h5, 4'hA, 4'hB, 4'h3, 4'hF});
        chk("v3_fin_cnt", fin_cnt - f0, 1);
        chk("v3_op", int'(alu_op), 4'hB);
        chk("v3_src", int'({srch, srcl}), 5);
        chk("v3_dst", int'({dsth, dstl}), 3);

        // Maximum operands, then a new entry clears the held result.
        keys('{4'h9, 4'h9, 4'h9, 4'hE, 4'h9, 4'h9, 4'h9, 4'hF});
        chk("v4_fin_src", fin_src, 16'h03E7);
        chk("v4_fin_dst", fin_dst, 16'h03E7);
        chk("v4_fin_op", fin_op, 4'hE);
        keys('{4'h7});
        chk("v4_state", int'(state), 1);
        chk("v4_src", int'({srch, srcl}), 7);
        chk("v4_dst", int'({dsth, dstl}), 0);
        chk("v4_calc", int'(calc), 0);
        do_reset();

        // Long hold yields one event; equals in S1 ignored.
        f0 = fin_cnt;
        press(4'h8, 50, 2);
        keys('{4'hF});
        chk("v5_src", int'({srch, srcl}), 8);
        chk("v5_flag", int'(flag), 1);
        chk("v5_state", int'(state), 1);
        chk("v5_fin_cnt", fin_cnt - f0, 0);
        do_reset();

        // Operator and equals in S0 ignored.
        keys('{4'hC, 4'hF});
        chk("v6_state", int'(state), 0);
        chk("v6_op", int'(alu_op), 0);

        // Reset mid-entry aborts.
        keys('{4'h4, 4'hA, 4'h6});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("v7_src", int'({srch, srcl}), 0);
        chk("v7_dst", int'({dsth, dstl}), 0);
        chk("v7_op", int'(alu_op), 0);
        chk("v7_state", int'(state), 0);
        f0 = fin_cnt;
        keys('{4'hF});
        chk("v7_fin_cnt", fin_cnt - f0, 0);

        // Key held through reset release produces no event.
        kp = 1'b1;
        kc = 4'h5;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        kp = 1'b0;
        repeat (3) @(negedge clk);
        chk("v8_state", int'(state), 0);
        chk("v8_src", int'({srch, srcl}), 0);

        // Back-to-back presses: a key detected right as finish pulses.
        f0 = fin_cnt;
        press(4'h2, 1, 1);
        press(4'hD, 1, 1);
        press(4'h6, 1, 1);
        press(4'hF, 1, 1);
        press(4'h3, 1, 3);
        chk("v9_fin_cnt", fin_cnt - f0, 1);
        chk("v9_fin_op", fin_op, 4'hD);
        chk("v9_state", int'(state), 1);
        chk("v9_src", int'({srch, srcl}), 3);

        // Reset in the finish cycle.
        keys('{4'h1, 4'hA, 4'h2});
        f0 = fin_cnt;
        press(4'hF, 1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("v10_state", int'(state), 0);
        chk("v10_calc", int'(calc), 0);
        chk("v10_fin_le1", int'(fin_cnt - f0 <= 1), 1);

        en_chk = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
